// File: rtl/salamander_pkg.sv
// Shared Salamander-4 definitions: default datapath widths used by the PC,
// fetch unit and decoder, plus the fetch controller state encoding.
package salamander_pkg;

   localparam int SAL_ADDR_W  = 5;
   localparam int SAL_INSTR_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Salamander-4 instruction fetch: issues one ROM read per fetch, waits out the
// ROM latency, then holds the instruction behind a valid/ready handshake.
module fetch_unit
   import salamander_pkg::*;
#(
   parameter int ADDR_W  = SAL_ADDR_W,
   parameter int INSTR_W = SAL_INSTR_W,
   parameter int MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic [ADDR_W-1:0]  pc_val,
   input  logic               pc_max,
   output logic               pc_inc,
   output logic               mem_rd,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               flush,
   output logic               halted
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   fetch_state_t        state;
   fetch_state_t        state_nxt;
   logic [CNT_W-1:0]    lat_cnt;
   logic [ADDR_W-1:0]   pend_addr;
   logic [ADDR_W-1:0]   instr_pc_q;
   logic [INSTR_W-1:0]  instr_q;

   // Capture happens only in WAIT, so a ROM return arriving after a flush or
   // reset has nowhere to land.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         pend_addr  <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ISSUE: begin
               pend_addr <= pc_val;
               lat_cnt   <= CNT_LOAD;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  if (!flush) begin
                     instr_q    <= mem_rdata;
                     instr_pc_q <= pend_addr;
                  end
               end else begin
                  lat_cnt <= lat_cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pc_max)
               state_nxt = HALT;
            else if (en)
               state_nxt = ISSUE;
         end
         ISSUE: state_nxt = flush ? IDLE : WAIT;
         WAIT: begin
            if (flush)
               state_nxt = IDLE;
            else if (lat_cnt == '0)
               state_nxt = HOLD;
         end
         // Flush wins over a same-cycle handshake; address all-ones halts
         // rather than letting the PC wrap back to 0.
         HOLD: begin
            if (flush)
               state_nxt = IDLE;
            else if (instr_ready) begin
               if ((&instr_pc_q) || pc_max)
                  state_nxt = HALT;
               else if (en)
                  state_nxt = ISSUE;
               else
                  state_nxt = IDLE;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_rd      = (state == ISSUE);
   assign pc_inc      = (state == ISSUE);
   assign mem_addr    = mem_rd ? pc_val : '0;
   assign instr_valid = (state == HOLD);
   assign halted      = (state == HALT);
   assign instr       = halted ? '0 : instr_q;
   assign instr_pc    = halted ? '0 : instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a MEM_LAT=1 and a MEM_LAT=3 instance, each with its own
// PC and ROM model, checked by a cycle table, hand sequences and a scoreboard.
module tb_fetch_unit;
   import salamander_pkg::*;

   localparam int AW = 5;
   localparam int IW = 8;

   typedef struct packed {
      logic [IW-1:0] ins;
      logic [AW-1:0] pc;
   } exp_t;

   typedef struct {
      logic          en;
      logic          rdy;
      logic          rd;
      logic          inc;
      logic [AW-1:0] addr;
      logic          vld;
      logic [IW-1:0] ins;
      logic [AW-1:0] ipc;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   logic flush;
   logic instr_ready;
   logic en [2];
   logic pc_max [2];
   logic [AW-1:0] pc_val [2];
   logic [IW-1:0] mem_rdata [2];
   logic pc_inc [2];
   logic mem_rd [2];
   logic instr_valid [2];
   logic halted [2];
   logic [AW-1:0] mem_addr [2];
   logic [AW-1:0] instr_pc [2];
   logic [IW-1:0] instr [2];

   logic s_rd [2];
   logic s_inc [2];
   logic s_vld [2];
   logic s_halt [2];
   logic [AW-1:0] s_addr [2];
   logic [AW-1:0] s_ipc [2];
   logic [IW-1:0] s_ins [2];

   logic          pv [2][4];
   logic [AW-1:0] pa [2][4];

   exp_t sb0[$];
   exp_t sb1[$];
   vec_t tbl [13];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .en(en[0]), .pc_val(pc_val[0]), .pc_max(pc_max[0]),
      .pc_inc(pc_inc[0]), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
      .mem_rdata(mem_rdata[0]), .instr(instr[0]), .instr_pc(instr_pc[0]),
      .instr_valid(instr_valid[0]), .instr_ready(instr_ready), .flush(flush),
      .halted(halted[0])
   );

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .rstn(rstn), .en(en[1]), .pc_val(pc_val[1]), .pc_max(pc_max[1]),
      .pc_inc(pc_inc[1]), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
      .mem_rdata(mem_rdata[1]), .instr(instr[1]), .instr_pc(instr_pc[1]),
      .instr_valid(instr_valid[1]), .instr_ready(instr_ready), .flush(flush),
      .halted(halted[1])
   );

   function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
      logic [IW-1:0] t;
      t = {a, 3'b011};
      return (a == '0) ? 8'hA5 : (t ^ 8'h5C);
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample at negedge, run the scoreboard, then after the edge
   // advance the PC and ROM models.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         s_rd[i]   = mem_rd[i];
         s_inc[i]  = pc_inc[i];
         s_vld[i]  = instr_valid[i];
         s_halt[i] = halted[i];
         s_addr[i] = mem_addr[i];
         s_ipc[i]  = instr_pc[i];
         s_ins[i]  = instr[i];
      end
      if (!rstn || flush) begin
         sb0.delete();
         sb1.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (s_vld[i] && instr_ready) begin
               if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                  check_output("sb unexpected accept", 32'(1), 32'(0));
               end else begin
                  e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                  check_output("sb instr", 32'(s_ins[i]), 32'(e.ins));
                  check_output("sb instr_pc", 32'(s_ipc[i]), 32'(e.pc));
               end
            end
            if (s_rd[i]) begin
               e.ins = rom_f(pc_val[i]);
               e.pc  = pc_val[i];
               if (i == 0) sb0.push_back(e);
               else        sb1.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (s_inc[i]) pc_val[i] = pc_val[i] + AW'(1);
         for (int k = 3; k > 0; k--) begin
            pv[i][k] = pv[i][k-1];
            pa[i][k] = pa[i][k-1];
         end
         pv[i][0] = s_rd[i];
         pa[i][0] = s_addr[i];
         mem_rdata[i] = pv[i][lat_of(i)-1] ? rom_f(pa[i][lat_of(i)-1]) : 8'hEE;
      end
   endtask

   task automatic wait_rd(input int i, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 16; n++) begin
         tick();
         if (s_rd[i]) begin
            ok = 1'b1;
            break;
         end
      end
      check_output("wait for mem_rd", 32'(ok), 32'(1));
   endtask

   task automatic apply_stimulus(input vec_t v);
      en[0]       = v.en;
      instr_ready = v.rdy;
   endtask

   initial begin
      bit ok;
      int t0;
      int bad;
      rstn = 1'b0; flush = 1'b0; instr_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; pc_max[i] = 1'b0; pc_val[i] = '0; mem_rdata[i] = 8'hEE;
         for (int k = 0; k < 4; k++) begin
            pv[i][k] = 1'b0;
            pa[i][k] = '0;
         end
      end

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 5'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, 5'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 5'd0};
      for (int r = 3; r < 8; r++)
         tbl[r] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'hA5, 5'd0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'hA5, 5'd0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 8'h00, 5'd0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 5'd0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, rom_f(5'd1), 5'd1};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 8'h00, 5'd0};

      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         check_output("reset mem_rd", 32'(s_rd[i]), 32'(0));
         check_output("reset pc_inc", 32'(s_inc[i]), 32'(0));
         check_output("reset instr_valid", 32'(s_vld[i]), 32'(0));
         check_output("reset halted", 32'(s_halt[i]), 32'(0));
         check_output("reset instr", 32'(s_ins[i]), 32'(0));
         check_output("reset instr_pc", 32'(s_ipc[i]), 32'(0));
      end
      rstn = 1'b1;

      // First fetch from 0, a stalled decoder, then back-to-back fetches.
      for (int r = 0; r < 13; r++) begin
         apply_stimulus(tbl[r]);
         tick();
         check_output($sformatf("row%0d mem_rd", r), 32'(s_rd[0]), 32'(tbl[r].rd));
         check_output($sformatf("row%0d pc_inc", r), 32'(s_inc[0]), 32'(tbl[r].inc));
         check_output($sformatf("row%0d mem_addr", r), 32'(s_addr[0]), 32'(tbl[r].addr));
         check_output($sformatf("row%0d instr_valid", r), 32'(s_vld[0]), 32'(tbl[r].vld));
         if (tbl[r].vld) begin
            check_output($sformatf("row%0d instr", r), 32'(s_ins[0]), 32'(tbl[r].ins));
            check_output($sformatf("row%0d instr_pc", r), 32'(s_ipc[0]), 32'(tbl[r].ipc));
         end
      end
      for (int n = 0; n < 4; n++) tick();
      check_output("drain idle valid", 32'(s_vld[0]), 32'(0));
      check_output("drain sb empty", 32'(sb0.size()), 32'(0));

      // MEM_LAT=3: valid four cycles after ISSUE.
      instr_ready = 1'b0;
      pc_val[1] = 5'd10;
      en[1] = 1'b1;
      wait_rd(1, ok);
      t0 = cyc;
      en[1] = 1'b0;
      for (int n = 0; n < 10 && !s_vld[1]; n++) tick();
      check_output("lat3 valid delay", 32'(cyc - t0), 32'(4));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      check_output("lat3 after accept", 32'(s_vld[1]), 32'(0));
      check_output("lat3 sb empty", 32'(sb1.size()), 32'(0));

      // Flush in WAIT, then flush in HOLD racing an accept.
      en[0] = 1'b1;
      wait_rd(0, ok);
      flush = 1'b1;
      pc_val[0] = 5'd20;
      tick();
      check_output("flush wait valid", 32'(s_vld[0]), 32'(0));
      flush = 1'b0;
      tick();
      check_output("post flush idle rd", 32'(s_rd[0]), 32'(0));
      tick();
      check_output("redirect rd", 32'(s_rd[0]), 32'(1));
      check_output("redirect addr", 32'(s_addr[0]), 32'(20));
      tick();
      instr_ready = 1'b1;
      flush = 1'b1;
      pc_val[0] = 5'd25;
      tick();
      check_output("hold before flush valid", 32'(s_vld[0]), 32'(1));
      flush = 1'b0;
      instr_ready = 1'b0;
      tick();
      check_output("flush hold valid", 32'(s_vld[0]), 32'(0));
      check_output("flush hold not accepted", 32'(s_rd[0]), 32'(0));
      tick();
      check_output("refetch addr", 32'(s_addr[0]), 32'(25));
      en[0] = 1'b0;
      instr_ready = 1'b1;
      for (int n = 0; n < 3; n++) tick();
      check_output("refetch sb empty", 32'(sb0.size()), 32'(0));

      // Fetch of the top address halts; pc_max in IDLE halts too.
      pc_val[0] = 5'd31;
      en[0] = 1'b1;
      wait_rd(0, ok);
      check_output("top addr", 32'(s_addr[0]), 32'(31));
      tick();
      tick();
      tick();
      check_output("halted", 32'(s_halt[0]), 32'(1));
      check_output("halt instr", 32'(s_ins[0]), 32'(0));
      bad = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (s_rd[0] || s_inc[0] || s_vld[0] || !s_halt[0]) bad++;
      end
      check_output("halt stays quiet", 32'(bad), 32'(0));
      instr_ready = 1'b0;
      pc_max[1] = 1'b1;
      tick();
      pc_max[1] = 1'b0;
      tick();
      check_output("pc_max halt", 32'(s_halt[1]), 32'(1));

      // Reset mid-WAIT on the slow instance; the late ROM data must be ignored.
      en[0] = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      check_output("reset exits halt", 32'(s_halt[0]), 32'(0));
      pc_val[1] = 5'd7;
      en[1] = 1'b1;
      wait_rd(1, ok);
      en[1] = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      check_output("rst wait rd", 32'(s_rd[1]), 32'(0));
      check_output("rst wait addr", 32'(s_addr[1]), 32'(0));
      check_output("rst wait valid", 32'(s_vld[1]), 32'(0));
      check_output("rst wait instr", 32'(s_ins[1]), 32'(0));
      bad = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (s_vld[1] || s_ins[1] != '0 || s_ipc[1] != '0) bad++;
      end
      check_output("late rdata ignored", 32'(bad), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
